// File: rtl/layer_sequencer.sv
// Sequences a bank of draw instances layer by layer for one frame and forwards
// the active instance's pixel stream to the VGA adapter through one register stage.
module layer_sequencer #(
    parameter int unsigned LAYERS              = 4,
    parameter logic [7:0]  TRANSPARENT         = 8'hE3,
    parameter bit          SKIP_TRANSPARENT_L0 = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frameStart,
    input  logic [LAYERS-1:0]     layerEn,
    input  logic [8*LAYERS-1:0]   xPos,
    input  logic [7*LAYERS-1:0]   yPos,
    output logic [LAYERS-1:0]     drawStart,
    output logic [8*LAYERS-1:0]   xInit,
    output logic [7*LAYERS-1:0]   yInit,
    input  logic [8*LAYERS-1:0]   drawX,
    input  logic [7*LAYERS-1:0]   drawY,
    input  logic [8*LAYERS-1:0]   drawColour,
    input  logic [LAYERS-1:0]     drawWriteEn,
    input  logic [LAYERS-1:0]     drawDone,
    output logic [7:0]            x,
    output logic [6:0]            y,
    output logic [7:0]            colour,
    output logic                  plot,
    output logic                  busy,
    output logic                  frameDone
);

    localparam int unsigned    CW   = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(LAYERS - 1);

    typedef enum logic [2:0] {IDLE, SELECT, RUN, RELEASE, FINISH} state_t;

    state_t                 state;
    logic [CW-1:0]          cur;
    logic [LAYERS-1:0]      en_q;
    logic [8*LAYERS-1:0]    x_q;
    logic [7*LAYERS-1:0]    y_q;
    logic                   run_first;

    logic [7:0]             sel_x;
    logic [6:0]             sel_y;
    logic [7:0]             sel_colour;
    logic                   sel_we;
    logic                   sel_done;
    logic                   pix_ok;

    assign xInit = x_q;
    assign yInit = y_q;

    // Only the current layer's stream is visible; layer 0 is opaque unless configured otherwise.
    always_comb begin
        sel_x      = drawX[8*cur +: 8];
        sel_y      = drawY[7*cur +: 7];
        sel_colour = drawColour[8*cur +: 8];
        sel_we     = drawWriteEn[cur];
        sel_done   = drawDone[cur];
        pix_ok     = (state == RUN || state == RELEASE) && sel_we &&
                     !(sel_colour == TRANSPARENT && (cur != '0 || SKIP_TRANSPARENT_L0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur       <= '0;
            en_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            run_first <= 1'b0;
            drawStart <= '0;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            plot      <= pix_ok;
            frameDone <= 1'b0;
            if (pix_ok) begin
                x      <= sel_x;
                y      <= sel_y;
                colour <= sel_colour;
            end

            case (state)
                IDLE: begin
                    if (frameStart) begin
                        en_q  <= layerEn;
                        x_q   <= xPos;
                        y_q   <= yPos;
                        cur   <= '0;
                        busy  <= 1'b1;
                        state <= SELECT;
                    end
                end
                SELECT: begin
                    if (en_q[cur]) begin
                        drawStart      <= '0;
                        drawStart[cur] <= 1'b1;
                        run_first      <= 1'b1;
                        state          <= RUN;
                    end else if (cur == LAST) begin
                        frameDone <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        cur <= cur + 1'b1;
                    end
                end
                RUN: begin
                    // done can read stale-high until the instance has seen its start
                    run_first <= 1'b0;
                    if (!run_first && sel_done) begin
                        drawStart <= '0;
                        state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!sel_done) begin
                        if (cur == LAST) begin
                            frameDone <= 1'b1;
                            state     <= FINISH;
                        end else begin
                            cur   <= cur + 1'b1;
                            state <= SELECT;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: behavioural draw-instance models plus
// a frame-level reference that lists the pixels the VGA side should receive.
module tb_layer_sequencer;

    localparam int         L    = 2;
    localparam int         W    = 3;
    localparam int         H    = 2;
    localparam int         NPIX = W * H;
    localparam logic [7:0] T    = 8'hE3;

    logic             clk, reset, frameStart;
    logic [L-1:0]     layerEn, drawStart, drawWriteEn, drawDone;
    logic [8*L-1:0]   xPos, xInit, drawX, drawColour;
    logic [7*L-1:0]   yPos, yInit, drawY;
    logic [7:0]       x, colour;
    logic [6:0]       y;
    logic             plot, busy, frameDone;

    layer_sequencer #(
        .LAYERS(L),
        .TRANSPARENT(T),
        .SKIP_TRANSPARENT_L0(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .frameStart(frameStart), .layerEn(layerEn),
        .xPos(xPos), .yPos(yPos), .drawStart(drawStart), .xInit(xInit), .yInit(yInit),
        .drawX(drawX), .drawY(drawY), .drawColour(drawColour), .drawWriteEn(drawWriteEn),
        .drawDone(drawDone), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
        .frameDone(frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Draw-instance models: W x H raster from xInit/yInit, done held `hold` cycles after start drops.
    logic [7:0] img [L][NPIX];
    int         hold [L];
    bit         noise_en [L];
    int         phase [L];
    int         k [L];
    int         cnt [L];
    logic [7:0] mx [L];
    logic [6:0] my [L];
    logic [7:0] mc [L];
    logic       mwe [L];
    logic       mdone [L];

    always @(posedge clk) begin
        for (int i = 0; i < L; i++) begin
            if (reset) begin
                phase[i] <= 0; k[i] <= 0; cnt[i] <= 0; mwe[i] <= 1'b0; mdone[i] <= 1'b0;
                mx[i] <= '0; my[i] <= '0; mc[i] <= '0;
            end else begin
                case (phase[i])
                    0: begin
                        mdone[i] <= 1'b0;
                        if (drawStart[i]) begin
                            phase[i] <= 1; k[i] <= 1; mwe[i] <= 1'b1;
                            mx[i] <= xInit[8*i +: 8]; my[i] <= yInit[7*i +: 7]; mc[i] <= img[i][0];
                        end else if (noise_en[i]) begin
                            mwe[i] <= 1'($urandom); mx[i] <= 8'($urandom);
                            my[i] <= 7'($urandom); mc[i] <= 8'($urandom);
                        end else begin
                            mwe[i] <= 1'b0;
                        end
                    end
                    1: begin
                        if (k[i] == NPIX) begin
                            mwe[i] <= 1'b0; mdone[i] <= 1'b1; phase[i] <= 2;
                        end else begin
                            mwe[i] <= 1'b1;
                            mx[i]  <= xInit[8*i +: 8] + 8'(k[i] % W);
                            my[i]  <= yInit[7*i +: 7] + 7'(k[i] / W);
                            mc[i]  <= img[i][k[i]];
                            k[i]   <= k[i] + 1;
                        end
                    end
                    2: begin
                        if (!drawStart[i]) begin
                            if (hold[i] <= 1) begin mdone[i] <= 1'b0; phase[i] <= 0; end
                            else begin cnt[i] <= hold[i] - 1; phase[i] <= 3; end
                        end
                    end
                    default: begin
                        if (cnt[i] == 1) begin mdone[i] <= 1'b0; phase[i] <= 0; end
                        else cnt[i] <= cnt[i] - 1;
                    end
                endcase
            end
        end
    end

    // An idle instance still shows its previous-frame done while start is first high.
    always_comb begin
        for (int i = 0; i < L; i++) begin
            drawX[8*i +: 8]      = mx[i];
            drawY[7*i +: 7]      = my[i];
            drawColour[8*i +: 8] = mc[i];
            drawWriteEn[i]       = mwe[i];
            drawDone[i]          = mdone[i] | (phase[i] == 0 && drawStart[i]);
        end
    end

    int          checks, errors, cyc;
    int          fd_count, n_plots, fs_cyc, done_cyc, ds_fall0;
    int          ds_first [L];
    bit          ds_seen [L];
    logic [22:0] last_plot;
    logic [22:0] expq [$];

    task automatic tick();
        logic [22:0] e;
        @(negedge clk);
        cyc++;
        if (!reset) begin
            checks++;
            assert ($countones(drawStart) <= 1) else begin
                errors++; $error("FAIL drawstart_onehot got=%b exp=one-hot-or-zero", drawStart);
            end
            for (int l = 0; l < L; l++)
                if (drawStart[l] && !ds_seen[l]) begin ds_seen[l] = 1'b1; ds_first[l] = cyc; end
            if (ds_seen[0] && !drawStart[0] && ds_fall0 < 0) ds_fall0 = cyc;
            if (plot) begin
                n_plots++;
                last_plot = {x, y, colour};
                checks++;
                assert (expq.size() > 0) else begin
                    errors++; $error("FAIL plot_extra got=(%0d,%0d,%02h) exp=no plot", x, y, colour);
                end
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    checks++;
                    assert (last_plot === e) else begin
                        errors++;
                        $error("FAIL pixel got=(%0d,%0d,%02h) exp=(%0d,%0d,%02h)",
                               x, y, colour, e[22:15], e[14:8], e[7:0]);
                    end
                end
            end
            if (frameDone) begin
                fd_count++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
    endtask

    task automatic clear_stats();
        for (int l = 0; l < L; l++) begin ds_seen[l] = 1'b0; ds_first[l] = -1; end
        ds_fall0 = -1; fd_count = 0; n_plots = 0; done_cyc = -1;
    endtask

    // Reference: enabled layers in order, raster order, transparent pixels dropped above layer 0.
    task automatic fill_expected(input logic [L-1:0] en, input logic [8*L-1:0] xp,
                                 input logic [7*L-1:0] yp);
        logic [7:0] px, col;
        logic [6:0] py;
        expq.delete();
        for (int l = 0; l < L; l++) begin
            if (en[l]) begin
                for (int p = 0; p < NPIX; p++) begin
                    col = img[l][p];
                    px  = xp[8*l +: 8] + 8'(p % W);
                    py  = yp[7*l +: 7] + 7'(p / W);
                    if (!(col == T && l != 0)) expq.push_back({px, py, col});
                end
            end
        end
    endtask

    task automatic run_frame(input logic [L-1:0] en, input logic [8*L-1:0] xp,
                             input logic [7*L-1:0] yp, input bit disturb);
        int exp_n, fe;
        fill_expected(en, xp, yp);
        exp_n = expq.size();
        clear_stats();
        for (int l = 0; l < L; l++) noise_en[l] = !en[l];
        layerEn = en; xPos = xp; yPos = yp; frameStart = 1'b1;
        fs_cyc = cyc;
        tick();
        frameStart = 1'b0;
        for (int t = 0; t < 300 && done_cyc < 0; t++) begin
            if (disturb && t == 4) begin xPos = ~xp; yPos = ~yp; frameStart = 1'b1; end
            if (disturb && t == 5) begin
                frameStart = 1'b0;
                checks++;
                assert (xInit === xp && yInit === yp) else begin
                    errors++; $error("FAIL init_stable got=%h/%h exp=%h/%h", xInit, yInit, xp, yp);
                end
            end
            tick();
        end
        checks++;
        assert (done_cyc >= 0) else begin
            errors++; $error("FAIL frame_timeout got=no frameDone exp=frameDone within 300 cycles");
        end
        if (done_cyc < 0) return;
        checks++;
        assert (busy === 1'b1) else begin errors++; $error("FAIL busy_at_done got=%b exp=1", busy); end
        tick();
        checks++;
        assert (busy === 1'b0 && frameDone === 1'b0) else begin
            errors++; $error("FAIL busy_fall got=busy%b/done%b exp=0/0", busy, frameDone);
        end
        tick(); tick();
        checks++;
        assert (fd_count === 1) else begin errors++; $error("FAIL framedone_count got=%0d exp=1", fd_count); end
        checks++;
        assert (n_plots === exp_n) else begin errors++; $error("FAIL plot_count got=%0d exp=%0d", n_plots, exp_n); end
        checks++;
        assert (expq.size() === 0) else begin errors++; $error("FAIL missing_plots got=%0d left exp=0", expq.size()); end
        checks++;
        assert (busy === 1'b0) else begin errors++; $error("FAIL no_restart got=busy%b exp=0", busy); end
        checks++;
        assert (xInit === xp && yInit === yp) else begin
            errors++; $error("FAIL init_latch got=%h/%h exp=%h/%h", xInit, yInit, xp, yp);
        end
        for (int l = 0; l < L; l++) begin
            checks++;
            assert (ds_seen[l] === en[l]) else begin
                errors++; $error("FAIL start_seen[%0d] got=%b exp=%b", l, ds_seen[l], en[l]);
            end
        end
        if (en == '0) begin
            checks++;
            assert (done_cyc - fs_cyc + 1 === L + 2) else begin
                errors++; $error("FAIL empty_latency got=%0d exp=%0d", done_cyc - fs_cyc + 1, L + 2);
            end
        end else begin
            fe = 0;
            while (!en[fe]) fe++;
            checks++;
            assert (ds_first[fe] - fs_cyc === 2 + fe) else begin
                errors++; $error("FAIL first_start got=%0d exp=%0d", ds_first[fe] - fs_cyc, 2 + fe);
            end
        end
        if (en[0] && en[1]) begin
            checks++;
            assert (ds_first[1] - ds_fall0 === hold[0] + 2) else begin
                errors++; $error("FAIL release_gap got=%0d exp=%0d", ds_first[1] - ds_fall0, hold[0] + 2);
            end
        end
    endtask

    initial begin
        logic [L-1:0]   ren;
        logic [8*L-1:0] rx;
        logic [7*L-1:0] ry;
        checks = 0; errors = 0; cyc = 0;
        reset = 1'b1; frameStart = 1'b0; layerEn = '0; xPos = '0; yPos = '0;
        for (int l = 0; l < L; l++) begin
            hold[l] = 1; noise_en[l] = 1'b0;
            for (int p = 0; p < NPIX; p++) img[l][p] = 8'h1C;
        end
        clear_stats();
        repeat (3) tick();
        checks++;
        assert ({drawStart, x, y, colour, plot, busy, frameDone, xInit, yInit} === '0) else begin
            errors++; $error("FAIL reset_state got=ds%b plot%b busy%b fd%b x%0d xi%h exp=all zero",
                             drawStart, plot, busy, frameDone, x, xInit);
        end
        reset = 1'b0;
        tick();

        // Two opaque 3x2 layers; the last pixel lands at (42,31).
        run_frame(2'b11, {8'd40, 8'd0}, {7'd30, 7'd0}, 1'b0);
        checks++;
        assert (n_plots === 12 && last_plot === {8'd42, 7'd31, 8'h1C}) else begin
            errors++; $error("FAIL frame_a got=%0d plots last=%h exp=12 last=%h",
                             n_plots, last_plot, {8'd42, 7'd31, 8'h1C});
        end

        // Transparent colour dropped on layer 1, kept on layer 0.
        img[1][1] = T; img[0][4] = T;
        run_frame(2'b11, {8'd40, 8'd0}, {7'd30, 7'd0}, 1'b0);
        checks++;
        assert (n_plots === 11) else begin errors++; $error("FAIL transparent got=%0d exp=11", n_plots); end

        run_frame(2'b10, {8'd10, 8'd20}, {7'd5, 7'd6}, 1'b0);
        run_frame(2'b01, {8'd11, 8'd21}, {7'd7, 7'd8}, 1'b0);
        run_frame(2'b00, {8'd12, 8'd22}, {7'd9, 7'd10}, 1'b0);

        hold[0] = 3;
        run_frame(2'b11, {8'd100, 8'd50}, {7'd60, 7'd20}, 1'b0);
        hold[0] = 1;

        // frameStart and new positions while busy must not disturb the frame.
        run_frame(2'b11, {8'd1, 8'd2}, {7'd3, 7'd4}, 1'b1);
        run_frame(2'b11, {8'd200, 8'd201}, {7'd100, 7'd101}, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int l = 0; l < L; l++) begin
                hold[l] = $urandom_range(1, 3);
                for (int p = 0; p < NPIX; p++)
                    img[l][p] = ($urandom_range(0, 3) == 0) ? T : 8'($urandom);
            end
            ren = L'($urandom); rx = (8*L)'($urandom); ry = (7*L)'($urandom);
            run_frame(ren, rx, ry, 1'b0);
        end

        // Reset while layer 1 is drawing, then a clean frame must start from layer 0.
        for (int l = 0; l < L; l++) begin hold[l] = 1; noise_en[l] = 1'b0; end
        fill_expected(2'b11, {8'd30, 8'd60}, {7'd40, 7'd50});
        clear_stats();
        layerEn = 2'b11; xPos = {8'd30, 8'd60}; yPos = {7'd40, 7'd50}; frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        for (int t = 0; t < 100 && !ds_seen[1]; t++) tick();
        checks++;
        assert (ds_seen[1] === 1'b1) else begin
            errors++; $error("FAIL layer1_start got=%b exp=1", ds_seen[1]);
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checks++;
        assert (drawStart === '0 && plot === 1'b0 && busy === 1'b0) else begin
            errors++; $error("FAIL midframe_reset got=ds%b plot%b busy%b exp=0/0/0", drawStart, plot, busy);
        end
        reset = 1'b0;
        expq.delete();
        tick();
        run_frame(2'b11, {8'd70, 8'd80}, {7'd11, 7'd22}, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Sits directly upstream of a bank of LAYERS draw instances and directly downstream of them towards the VGA adapter.
- On each frame request it latches per-layer positions. It then starts each enabled draw instance in turn (layer 0 = background, first) and waits for that instance's done.
- While a layer is active, it forwards that instance's pixel stream to the VGA adapter through a one-cycle register stage.
- Pixels whose colour equals TRANSPARENT are dropped, so sprites composite over earlier layers.

Parameters:
- LAYERS, 4, number of draw instances sequenced (2..8).
- TRANSPARENT, 8'hE3, colour value that is never plotted.
- SKIP_TRANSPARENT_L0, 0, when 1 the transparency filter also applies to layer 0; when 0, layer 0 plots every pixel.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frameStart  in  1  request pulse or level; sampled only in IDLE.
- layerEn  in  LAYERS  per-layer enable, latched at frame acceptance.
- xPos  in  8*LAYERS  packed layer x origins, layer i at [8i+7:8i].
- yPos  in  7*LAYERS  packed layer y origins, layer i at [7i+6:7i].
- drawStart  out  LAYERS  start level to draw instance i (one-hot or zero).
- xInit  out  8*LAYERS  latched x origin per instance.
- yInit  out  7*LAYERS  latched y origin per instance.
- drawX  in  8*LAYERS  xOut of each instance.
- drawY  in  7*LAYERS  yOut of each instance.
- drawColour  in  8*LAYERS  colour of each instance.
- drawWriteEn  in  LAYERS  writeEn of each instance.
- drawDone  in  LAYERS  done of each instance.
- x  out  8  registered pixel x to VGA.
- y  out  7  registered pixel y to VGA.
- colour  out  8  registered pixel colour to VGA.
- plot  out  1  registered write strobe to VGA.
- busy  out  1  high in any state other than IDLE.
- frameDone  out  1  one-cycle pulse when the last enabled layer has released.

Behaviour:
- Reset (sync, priority over everything):
  - state=IDLE, cur=0.
  - drawStart, x, y, colour, plot, busy, frameDone = 0.
  - Latched layerEn/xPos/yPos registers cleared to 0.
- FSM states: IDLE, SELECT, RUN, RELEASE, FINISH.
- IDLE:
  - On frameStart=1, latch layerEn, xPos and yPos; cur=0; go to SELECT.
  - Inputs are not sampled in any other state; frameStart while busy is ignored.
- SELECT (single cycle):
  - If latched enable[cur]=1, go to RUN.
  - Else if cur==LAYERS-1, go to FINISH.
  - Else cur+1 and stay in SELECT.
  - An all-zero enable mask reaches FINISH after LAYERS cycles without touching any instance.
- RUN:
  - drawStart[cur]=1.
  - Stay in RUN until drawDone[cur]=1, then go to RELEASE.
  - drawDone[cur] is ignored during the first RUN cycle. The instance's done may still read stale-high (its y is left at the terminal value from the previous frame) until the instance leaves its idle state.
- RELEASE:
  - drawStart all 0.
  - Wait until drawDone[cur]=0 (instance back in idle), then:
    - if cur==LAYERS-1, go to FINISH;
    - else cur+1 and go to SELECT.
- FINISH: frameDone=1 for exactly one cycle, then go to IDLE.
- Pixel path, registered, latency 1 cycle from drawWriteEn[cur]:
  - plot <= (state==RUN || state==RELEASE) && drawWriteEn[cur] && !(drawColour[cur]==TRANSPARENT && (cur!=0 || SKIP_TRANSPARENT_L0)).
  - x, y and colour are loaded from the cur slice whenever plot would be loaded 1; otherwise they hold.
- Instances other than cur never reach the outputs. Their writeEn is ignored even if asserted.
- xInit/yInit are driven continuously from the latched registers. They are stable for the whole frame even if xPos/yPos change mid-frame.
- Reset mid-frame: all drawStart drop in the same cycle reset is sampled. The next frame restarts at layer 0.

Test Plan:
- LAYERS=2, layerEn=2'b11, xPos={8'd40,8'd0}, yPos={7'd30,7'd0}, instance models run 3x2 images with all colours 8'h1C → drawStart[0] then drawStart[1]; 12 plots total, the last at (42,31); frameDone exactly once; busy falls with frameDone.
- Layer 1 image containing 8'hE3 at pixel (1,0), SKIP_TRANSPARENT_L0=0 → that pixel is not plotted for layer 1 (11 plots), while 8'hE3 pixels in layer 0 are plotted.
- layerEn=2'b10 → drawStart[0] never asserted; layer 1 runs; SELECT skips layer 0 in 1 cycle. layerEn=0 → frameDone exactly LAYERS+2 cycles after frameStart, zero plots.
- Model holds drawDone[0] high for 3 cycles after start drops → sequencer stays in RELEASE for those 3 cycles; drawStart[1] rises only after drawDone[0]=0.
- Change xPos and pulse frameStart while busy → no restart; xInit unchanged until the next accepted frame.
- Assert reset during RUN of layer 1 → drawStart=0 and plot=0 on the next edge; the next frameStart begins at layer 0.
